id_ex_pipe_reg: RTL and testbench

//   ID/EX pipeline register: directly downstream of the opcode control decoder.

---
 rtl/id_ex_pipe_reg.sv | 168 ++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register. It detects load-use hazards and inserts bubbles for
// them, squashes the slot on a branch flush and counts inserted bubbles.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_regwrite,
  input  logic              id_memtoreg,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic              id_alusrc,
  input  logic              id_regdest,
  input  logic [2:0]        id_aluop,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic              ex_alusrc,
  output logic              ex_regdest,
  output logic [2:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              r_valid;
  logic              r_regwrite;
  logic              r_memtoreg;
  logic              r_memread;
  logic              r_memwrite;
  logic              r_branch;
  logic              r_alusrc;
  logic              r_regdest;
  logic [2:0]        r_aluop;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc_plus4;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_wreg;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_uses_rt;
  logic w_rs_match;
  logic w_rt_match;
  logic w_load_use;
  logic w_bubble;

  // id_valid gates the whole term first so X on don't-care decoder fields
  // cannot leak into the stall.
  always_comb begin
    w_uses_rt  = ~id_alusrc | id_memwrite;
    w_rs_match = (r_rt == id_rs);
    w_rt_match = w_uses_rt & (r_rt == id_rt);
    w_load_use = 1'b0;
    if (id_valid && r_valid && r_memread && !flush && (r_rt != '0)) begin
      w_load_use = w_rs_match | w_rt_match;
    end
  end

  assign w_bubble = flush | (~ex_stall & w_load_use);

  // Data fields keep their old value on a bubble; only control is squashed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regdest  <= 1'b0;
      r_aluop    <= 3'b000;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_pc_plus4 <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_wreg     <= '0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regdest  <= 1'b0;
      r_aluop    <= 3'b000;
    end else if (!ex_stall) begin
      r_valid    <= id_valid;
      r_regwrite <= id_valid ? id_regwrite : 1'b0;
      r_memtoreg <= id_valid ? id_memtoreg : 1'b0;
      r_memread  <= id_valid ? id_memread  : 1'b0;
      r_memwrite <= id_valid ? id_memwrite : 1'b0;
      r_branch   <= id_valid ? id_branch   : 1'b0;
      r_alusrc   <= id_valid ? id_alusrc   : 1'b0;
      r_regdest  <= id_valid ? id_regdest  : 1'b0;
      r_aluop    <= id_valid ? id_aluop    : 3'b000;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= id_imm;
      r_pc_plus4 <= id_pc_plus4;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
      r_wreg     <= (id_valid && id_regdest) ? id_rd : id_rt;
    end
  end

  // Only a hazard bubble counts; flush bubbles and held cycles do not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!flush && !ex_stall && w_load_use && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign ex_valid       = r_valid;
  assign ex_regwrite    = r_regwrite;
  assign ex_memtoreg    = r_memtoreg;
  assign ex_memread     = r_memread;
  assign ex_memwrite    = r_memwrite;
  assign ex_branch      = r_branch;
  assign ex_alusrc      = r_alusrc;
  assign ex_regdest     = r_regdest;
  assign ex_aluop       = r_aluop;
  assign ex_rs_data     = r_rs_data;
  assign ex_rt_data     = r_rt_data;
  assign ex_imm         = r_imm;
  assign ex_pc_plus4    = r_pc_plus4;
  assign ex_rs          = r_rs;
  assign ex_rt          = r_rt;
  assign ex_rd          = r_rd;
  assign ex_wreg        = r_wreg;
  assign load_use_stall = w_load_use;
  assign bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed hazard/priority/reset cases
// plus a randomized run against a slot-level model of the EX stage.
module tb_id_ex_pipe_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 5;

  logic clk, rst;
  logic id_valid, id_regwrite, id_memtoreg, id_memread, id_memwrite;
  logic id_branch, id_alusrc, id_regdest;
  logic [2:0] id_aluop;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc_plus4;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic flush, ex_stall;
  logic ex_valid, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite;
  logic ex_branch, ex_alusrc, ex_regdest;
  logic [2:0] ex_aluop;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd, ex_wreg;
  logic load_use_stall;
  logic [CW-1:0] bubble_cnt;

  id_ex_pipe_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_alusrc(id_alusrc), .id_regdest(id_regdest),
    .id_aluop(id_aluop), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc_plus4(id_pc_plus4), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_alusrc(ex_alusrc),
    .ex_regdest(ex_regdest), .ex_aluop(ex_aluop), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc_plus4(ex_pc_plus4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wreg(ex_wreg),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Model of the EX slot: ctrl = {regwrite,memtoreg,memread,memwrite,branch,alusrc,regdest}
  logic          m_valid;
  logic [6:0]    m_ctrl;
  logic [2:0]    m_aluop;
  logic [DW-1:0] m_rs_data, m_rt_data, m_imm, m_pc;
  logic [AW-1:0] m_rs, m_rt, m_rd, m_wreg;
  int            m_cnt;
  int            cnt_max;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_aluop = '0; m_cnt = 0;
    m_rs_data = '0; m_rt_data = '0; m_imm = '0; m_pc = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_wreg = '0;
  endtask

  // The EX slot holds a load whose nonzero destination the ID instruction reads.
  function automatic logic model_hazard();
    logic reads_rt;
    if (!id_valid || !m_valid || !m_ctrl[4] || flush || m_rt == 0) return 1'b0;
    reads_rt = !id_alusrc || id_memwrite;
    return (m_rt == id_rs) || (reads_rt && m_rt == id_rt);
  endfunction

  task automatic model_edge(input logic hz);
    if (flush || (!ex_stall && hz)) begin
      m_valid = 1'b0; m_ctrl = '0; m_aluop = '0;
      if (!flush && m_cnt < cnt_max) m_cnt++;
    end else if (!ex_stall) begin
      m_valid = id_valid;
      m_ctrl = id_valid ? {id_regwrite, id_memtoreg, id_memread, id_memwrite,
                           id_branch, id_alusrc, id_regdest} : 7'd0;
      m_aluop = id_valid ? id_aluop : 3'd0;
      m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
      m_pc = id_pc_plus4; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_wreg = id_regdest ? id_rd : id_rt;
    end
  endtask

  task automatic compare_all();
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_ctrl", {ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite,
                    ex_branch, ex_alusrc, ex_regdest}, m_ctrl);
    chk("ex_aluop", ex_aluop, m_aluop);
    chk("bubble_cnt", bubble_cnt, m_cnt);
    if (m_valid) begin
      chk("ex_rs_data", ex_rs_data, m_rs_data);
      chk("ex_rt_data", ex_rt_data, m_rt_data);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_pc_plus4", ex_pc_plus4, m_pc);
      chk("ex_specs", {ex_rs, ex_rt, ex_rd}, {m_rs, m_rt, m_rd});
      chk("ex_wreg", ex_wreg, m_wreg);
    end
  endtask

  // Inputs are already driven; check the stall, take the edge, check outputs.
  task automatic cycle();
    logic hz;
    #1;
    hz = model_hazard();
    chk("load_use_stall", load_use_stall, hz);
    @(posedge clk);
    model_edge(hz);
    #1;
    compare_all();
  endtask

  task automatic set_instr(input logic v, input logic [6:0] ctrl, input logic [2:0] op,
                           input int rs, input int rt, input int rd);
    id_valid = v;
    {id_regwrite, id_memtoreg, id_memread, id_memwrite, id_branch, id_alusrc,
     id_regdest} = ctrl;
    id_aluop = op;
    id_rs = AW'(rs); id_rt = AW'(rt); id_rd = AW'(rd);
    id_rs_data = $urandom; id_rt_data = $urandom;
    id_imm = $urandom; id_pc_plus4 = $urandom;
  endtask

  localparam logic [6:0] CtlR  = 7'b1000001;  // regwrite, regdest
  localparam logic [6:0] CtlLw = 7'b1110010;  // regwrite, memtoreg, memread, alusrc
  localparam logic [6:0] CtlAi = 7'b1000010;  // regwrite, alusrc

  logic [CW-1:0] all_ones;

  initial begin
    cnt_max = (1 << CW) - 1;
    all_ones = '1;
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    set_instr(1'b0, 7'd0, 3'd0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", ex_valid, 1'b0);
    chk("reset_cnt", bubble_cnt, '0);
    compare_all();
    rst = 1'b0;

    // Pass-through R-type
    set_instr(1'b1, CtlR, 3'b010, 1, 2, 3);
    cycle();
    chk("rtype_aluop", ex_aluop, 3'b010);
    chk("rtype_wreg", ex_wreg, 5'd3);
    chk("rtype_valid", ex_valid, 1'b1);

    // Load-use: LW rt=8 then add rs=8
    set_instr(1'b1, CtlLw, 3'b000, 1, 8, 0);
    cycle();
    set_instr(1'b1, CtlR, 3'b010, 8, 9, 10);
    #1 chk("lu_stall", load_use_stall, 1'b1);
    cycle();
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_cnt", bubble_cnt, 5'd1);
    #1 chk("lu_stall_gone", load_use_stall, 1'b0);
    cycle();
    chk("lu_add_enters", ex_valid, 1'b1);
    chk("lu_add_wreg", ex_wreg, 5'd10);

    // No false hazard: rt=0, and addi not reading rt
    set_instr(1'b1, CtlLw, 3'b000, 1, 0, 0);
    cycle();
    set_instr(1'b1, CtlR, 3'b010, 0, 0, 4);
    #1 chk("nohaz_r0", load_use_stall, 1'b0);
    cycle();
    set_instr(1'b1, CtlLw, 3'b000, 1, 5, 0);
    cycle();
    set_instr(1'b1, CtlAi, 3'b000, 6, 5, 0);
    #1 chk("nohaz_addi", load_use_stall, 1'b0);
    cycle();

    // Priority: flush over ex_stall over hazard
    set_instr(1'b1, CtlLw, 3'b000, 1, 7, 0);
    cycle();
    set_instr(1'b1, CtlR, 3'b010, 7, 2, 3);
    flush = 1'b1; ex_stall = 1'b1;
    #1 chk("prio_stall", load_use_stall, 1'b0);
    cycle();
    chk("prio_bubble", ex_valid, 1'b0);
    chk("prio_cnt", bubble_cnt, 5'd1);
    flush = 1'b0; ex_stall = 1'b0;
    set_instr(1'b1, CtlR, 3'b110, 4, 5, 6);
    cycle();
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1'b1, 7'($urandom), 3'($urandom), 1, 2, 9);
      cycle();
      chk("hold_aluop", ex_aluop, 3'b110);
      chk("hold_wreg", ex_wreg, 5'd6);
      chk("hold_valid", ex_valid, 1'b1);
    end
    ex_stall = 1'b0;

    // Saturation
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      set_instr(1'b1, CtlLw, 3'b000, 1, 3, 0);
      cycle();
      set_instr(1'b1, CtlR, 3'b010, 3, 1, 2);
      cycle();
      cycle();
    end
    chk("sat_cnt", bubble_cnt, all_ones);

    // Randomized run with an asynchronous reset midway
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst = 1'b1;
        #1;
        chk("async_valid", ex_valid, 1'b0);
        chk("async_regwrite", ex_regwrite, 1'b0);
        chk("async_cnt", bubble_cnt, '0);
        model_reset();
        rst = 1'b0;
      end
      set_instr(($urandom % 8) != 0,
                {1'($urandom), 1'($urandom), ($urandom % 3) != 0, 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom)},
                3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 31));
      flush = ($urandom % 10) == 0;
      ex_stall = ($urandom % 7) == 0;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
